// File: rtl/wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter
// Shares one Wishbone memory port between a CPU master and a DMA master.
// A single transfer is granted at a time. The arbiter always passes through
// IDLE between two grants. A grant that waits too long for the memory ack is
// terminated with a forced ack carrying 32'hDEAD_BEEF and a timeout pulse.
//
// State table:
//   state   | meaning
//   --------+----------------------------------------------------------------
//   IDLE    | no owner, mem_* driven to 0, arbitration of incoming requests
//   GNT_CPU | CPU owns the memory port, waiting for mem_ack_i
//   GNT_DMA | DMA owns the memory port, waiting for mem_ack_i
//
// Parameters:
//   TIMEOUT  wait cycles allowed in a grant before the forced ack (8-bit)
//   RR_EN    1 = round-robin between masters, 0 = CPU always wins ties
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   cpu_*_i / cpu_ack_o, cpu_dat_o   CPU Wishbone slave side
//   dma_*_i / dma_ack_o, dma_dat_o   DMA Wishbone slave side
//   mem_*_o / mem_ack_i, mem_dat_i   shared memory Wishbone master side
//   grant_o                     one-hot {dma, cpu} current owner
//   timeout_o                   one-cycle pulse when a grant times out
// -----------------------------------------------------------------------------
module wb_mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter bit RR_EN   = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        cpu_cyc_i,
    input  logic        cpu_stb_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_adr_i,
    input  logic [31:0] cpu_dat_i,
    output logic        cpu_ack_o,
    output logic [31:0] cpu_dat_o,

    input  logic        dma_cyc_i,
    input  logic        dma_stb_i,
    input  logic        dma_we_i,
    input  logic [3:0]  dma_sel_i,
    input  logic [31:0] dma_adr_i,
    input  logic [31:0] dma_dat_i,
    output logic        dma_ack_o,
    output logic [31:0] dma_dat_o,

    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_adr_o,
    output logic [31:0] mem_dat_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_dat_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [31:0] TMO_DATA  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DMA = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_grant;
    logic [7:0]  r_wait_cnt;
    logic        r_last_dma;
    logic        r_served;

    logic        w_cpu_req;
    logic        w_dma_req;
    logic        w_gnt_cpu;
    logic        w_gnt_dma;
    logic        w_own_cyc;
    logic        w_ack_live;
    logic        w_timeout;
    logic        w_done;
    logic        w_pick_dma;
    logic [31:0] w_rsp_dat;

    assign w_cpu_req = cpu_cyc_i & cpu_stb_i;
    assign w_dma_req = dma_cyc_i & dma_stb_i;
    assign w_gnt_cpu = (r_state == GNT_CPU);
    assign w_gnt_dma = (r_state == GNT_DMA);

    // The owner still holding cyc is what keeps a grant alive; once it lets
    // go, neither a late memory ack nor a timeout is reported to it.
    assign w_own_cyc = (w_gnt_cpu & cpu_cyc_i) | (w_gnt_dma & dma_cyc_i);

    // Acks are suppressed while reset is asserted so a reset in the middle of
    // a transfer never completes it on either side.
    assign w_ack_live = w_own_cyc & mem_ack_i & ~wb_rst_i;

    // A real ack arriving in the terminal-count cycle wins over the timeout.
    assign w_timeout  = w_own_cyc & ~mem_ack_i & ~wb_rst_i
                        & (r_wait_cnt == TIMEOUT_C);
    assign w_done     = w_ack_live | w_timeout;

    // Tie-break: a single last_dma bit cannot tell "CPU served last" from
    // "nothing served since reset", so r_served marks that at least one
    // transfer completed. Until then the CPU wins a tie; afterwards the
    // master not served last wins when round-robin is enabled.
    assign w_pick_dma = w_dma_req
                        & (~w_cpu_req | (RR_EN & r_served & ~r_last_dma));

    // Shared memory port mux: follows the owner, all-zero while idle.
    always_comb begin
        mem_cyc_o = 1'b0;
        mem_stb_o = 1'b0;
        mem_we_o  = 1'b0;
        mem_sel_o = 4'h0;
        mem_adr_o = 32'h0;
        mem_dat_o = 32'h0;
        if (w_gnt_cpu) begin
            mem_cyc_o = cpu_cyc_i;
            mem_stb_o = cpu_stb_i;
            mem_we_o  = cpu_we_i;
            mem_sel_o = cpu_sel_i;
            mem_adr_o = cpu_adr_i;
            mem_dat_o = cpu_dat_i;
        end else if (w_gnt_dma) begin
            mem_cyc_o = dma_cyc_i;
            mem_stb_o = dma_stb_i;
            mem_we_o  = dma_we_i;
            mem_sel_o = dma_sel_i;
            mem_adr_o = dma_adr_i;
            mem_dat_o = dma_dat_i;
        end
    end

    assign w_rsp_dat = w_timeout ? TMO_DATA : mem_dat_i;

    assign cpu_ack_o = w_gnt_cpu & w_done;
    assign dma_ack_o = w_gnt_dma & w_done;
    assign cpu_dat_o = cpu_ack_o ? w_rsp_dat : 32'h0;
    assign dma_dat_o = dma_ack_o ? w_rsp_dat : 32'h0;
    assign timeout_o = w_timeout;
    assign grant_o   = r_grant;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= IDLE;
            r_grant    <= 2'b00;
            r_wait_cnt <= 8'h00;
            r_last_dma <= 1'b0;
            r_served   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Holding the counter at zero here clears it on grant entry.
                    r_wait_cnt <= 8'h00;
                    if (w_cpu_req | w_dma_req) begin
                        if (w_pick_dma) begin
                            r_state <= GNT_DMA;
                            r_grant <= 2'b10;
                        end else begin
                            r_state <= GNT_CPU;
                            r_grant <= 2'b01;
                        end
                    end
                end

                GNT_CPU, GNT_DMA: begin
                    if (!w_own_cyc) begin
                        // Owner abandoned the cycle: no completion recorded.
                        r_state    <= IDLE;
                        r_grant    <= 2'b00;
                        r_wait_cnt <= 8'h00;
                    end else if (w_done) begin
                        r_state    <= IDLE;
                        r_grant    <= 2'b00;
                        r_wait_cnt <= 8'h00;
                        r_last_dma <= w_gnt_dma;
                        r_served   <= 1'b1;
                    end else if (r_wait_cnt != TIMEOUT_C) begin
                        r_wait_cnt <= r_wait_cnt + 8'h01;
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_grant    <= 2'b00;
                    r_wait_cnt <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_wb_mem_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_cyc, cpu_stb, cpu_we;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_adr, cpu_wdat;
    logic        dma_cyc, dma_stb, dma_we;
    logic [3:0]  dma_sel;
    logic [31:0] dma_adr, dma_wdat;
    logic        mem_ack;
    logic [31:0] mem_rdat;

    // instance 0: round-robin, instance 1: fixed CPU priority
    logic        a_cpu_ack, a_dma_ack, a_mem_cyc, a_mem_stb, a_mem_we, a_tmo;
    logic [31:0] a_cpu_dat, a_dma_dat, a_mem_adr, a_mem_dat;
    logic [3:0]  a_mem_sel;
    logic [1:0]  a_grant;
    logic        b_cpu_ack, b_dma_ack, b_mem_cyc, b_mem_stb, b_mem_we, b_tmo;
    logic [31:0] b_cpu_dat, b_dma_dat, b_mem_adr, b_mem_dat;
    logic [3:0]  b_mem_sel;
    logic [1:0]  b_grant;

    wb_mem_arbiter #(.TIMEOUT(TO), .RR_EN(1'b1)) u_rr (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cpu_cyc_i(cpu_cyc), .cpu_stb_i(cpu_stb), .cpu_we_i(cpu_we),
        .cpu_sel_i(cpu_sel), .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_wdat),
        .cpu_ack_o(a_cpu_ack), .cpu_dat_o(a_cpu_dat),
        .dma_cyc_i(dma_cyc), .dma_stb_i(dma_stb), .dma_we_i(dma_we),
        .dma_sel_i(dma_sel), .dma_adr_i(dma_adr), .dma_dat_i(dma_wdat),
        .dma_ack_o(a_dma_ack), .dma_dat_o(a_dma_dat),
        .mem_cyc_o(a_mem_cyc), .mem_stb_o(a_mem_stb), .mem_we_o(a_mem_we),
        .mem_sel_o(a_mem_sel), .mem_adr_o(a_mem_adr), .mem_dat_o(a_mem_dat),
        .mem_ack_i(mem_ack), .mem_dat_i(mem_rdat),
        .grant_o(a_grant), .timeout_o(a_tmo)
    );

    wb_mem_arbiter #(.TIMEOUT(TO), .RR_EN(1'b0)) u_fx (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cpu_cyc_i(cpu_cyc), .cpu_stb_i(cpu_stb), .cpu_we_i(cpu_we),
        .cpu_sel_i(cpu_sel), .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_wdat),
        .cpu_ack_o(b_cpu_ack), .cpu_dat_o(b_cpu_dat),
        .dma_cyc_i(dma_cyc), .dma_stb_i(dma_stb), .dma_we_i(dma_we),
        .dma_sel_i(dma_sel), .dma_adr_i(dma_adr), .dma_dat_i(dma_wdat),
        .dma_ack_o(b_dma_ack), .dma_dat_o(b_dma_dat),
        .mem_cyc_o(b_mem_cyc), .mem_stb_o(b_mem_stb), .mem_we_o(b_mem_we),
        .mem_sel_o(b_mem_sel), .mem_adr_o(b_mem_adr), .mem_dat_o(b_mem_dat),
        .mem_ack_i(mem_ack), .mem_dat_i(mem_rdat),
        .grant_o(b_grant), .timeout_o(b_tmo)
    );

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        cpu_ack;
        logic [31:0] cpu_dat;
        logic        dma_ack;
        logic [31:0] dma_dat;
        logic [1:0]  grant;
        logic        tmo;
    } outs_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner 0=none 1=cpu 2=dma, last 0=none served yet,
    // wait = cycles spent in the current grant without completion.
    int m_owner [2] = '{0, 0};
    int m_last  [2] = '{0, 0};
    int m_wait  [2] = '{0, 0};
    int m_rr    [2] = '{1, 0};

    function automatic outs_t model_out(int k);
        outs_t       o;
        bit          live;
        bit          ack;
        bit          tmo;
        logic [31:0] d;
        o    = '0;
        live = 1'b0;
        ack  = 1'b0;
        tmo  = 1'b0;
        if (m_owner[k] == 1) begin
            o.cyc = cpu_cyc; o.stb = cpu_stb; o.we = cpu_we;
            o.sel = cpu_sel; o.adr = cpu_adr; o.dat = cpu_wdat;
            o.grant = 2'b01; live = cpu_cyc;
        end else if (m_owner[k] == 2) begin
            o.cyc = dma_cyc; o.stb = dma_stb; o.we = dma_we;
            o.sel = dma_sel; o.adr = dma_adr; o.dat = dma_wdat;
            o.grant = 2'b10; live = dma_cyc;
        end
        if (live && !rst) begin
            if (mem_ack) ack = 1'b1;
            else if (m_wait[k] == TO) tmo = 1'b1;
        end
        if (ack || tmo) begin
            d = tmo ? 32'hDEAD_BEEF : mem_rdat;
            if (m_owner[k] == 1) begin o.cpu_ack = 1'b1; o.cpu_dat = d; end
            else begin o.dma_ack = 1'b1; o.dma_dat = d; end
            o.tmo = tmo;
        end
        return o;
    endfunction

    task automatic model_step();
        bit cr, dr, live;
        for (int k = 0; k < 2; k++) begin
            cr = cpu_cyc && cpu_stb;
            dr = dma_cyc && dma_stb;
            if (rst) begin
                m_owner[k] = 0; m_last[k] = 0; m_wait[k] = 0;
            end else if (m_owner[k] == 0) begin
                m_wait[k] = 0;
                if (cr && dr) m_owner[k] = (m_rr[k] == 1 && m_last[k] == 1) ? 2 : 1;
                else if (cr) m_owner[k] = 1;
                else if (dr) m_owner[k] = 2;
            end else begin
                live = (m_owner[k] == 1) ? cpu_cyc : dma_cyc;
                if (!live) begin
                    m_owner[k] = 0;
                end else if (mem_ack || m_wait[k] == TO) begin
                    m_last[k]  = m_owner[k];
                    m_owner[k] = 0;
                end else begin
                    m_wait[k]++;
                end
            end
        end
    endtask

    function automatic outs_t dut_out(int k);
        if (k == 0)
            return {a_mem_cyc, a_mem_stb, a_mem_we, a_mem_sel, a_mem_adr, a_mem_dat,
                    a_cpu_ack, a_cpu_dat, a_dma_ack, a_dma_dat, a_grant, a_tmo};
        return {b_mem_cyc, b_mem_stb, b_mem_we, b_mem_sel, b_mem_adr, b_mem_dat,
                b_cpu_ack, b_cpu_dat, b_dma_ack, b_dma_dat, b_grant, b_tmo};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_sel = 4'h0; cpu_adr = 0; cpu_wdat = 0;
        dma_cyc = 0; dma_stb = 0; dma_we = 0; dma_sel = 4'h0; dma_adr = 0; dma_wdat = 0;
        mem_ack = 0; mem_rdat = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        cpu_cyc = 1; cpu_stb = 1; dma_cyc = 1; dma_stb = 1; mem_ack = 1;
        tick();
        tick();
        #2;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (dut_out(k) !== model_out(k)) begin
                n_fail++;
                $display("FAIL reset_model[%0d]: got %h want %h", k, dut_out(k), model_out(k));
            end
        end
        n_checks++;
        if ({a_grant, a_mem_cyc, a_cpu_ack, a_dma_ack, a_tmo} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got grant=%b cyc=%b acks=%b%b tmo=%b want all 0",
                     a_grant, a_mem_cyc, a_cpu_ack, a_dma_ack, a_tmo);
        end
        tick();
        rst = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_cpu_read();
        int acks = 0;
        do_reset();
        cpu_cyc = 1; cpu_stb = 1; cpu_we = 0; cpu_sel = 4'hF; cpu_adr = $urandom;
        for (int i = 0; i < 6; i++) begin
            mem_ack  = (i == 3);
            mem_rdat = (i == 3) ? 32'h1234_5678 : $urandom;
            if (i == 4) begin cpu_cyc = 0; cpu_stb = 0; end
            #2;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (dut_out(k) !== model_out(k)) begin
                    n_fail++;
                    $display("FAIL cpu_read_model[%0d] cyc %0d: got %h want %h", k, i, dut_out(k), model_out(k));
                end
            end
            if (a_cpu_ack === 1'b1) acks++;
            if (i == 1) begin
                n_checks++;
                if (a_mem_stb !== 1'b1 || a_grant !== 2'b01) begin
                    n_fail++;
                    $display("FAIL cpu_read_latency: got stb=%b grant=%b want 1/01", a_mem_stb, a_grant);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (a_cpu_ack !== 1'b1 || a_cpu_dat !== 32'h1234_5678 || a_dma_ack !== 1'b0 || a_grant !== 2'b01) begin
                    n_fail++;
                    $display("FAIL cpu_read_ack: got ack=%b dat=%h dma_ack=%b grant=%b want 1/12345678/0/01",
                             a_cpu_ack, a_cpu_dat, a_dma_ack, a_grant);
                end
            end
            tick();
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL cpu_read_ack_count: got %0d want 1", acks);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_a [9] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        logic [1:0] exp_b [9] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            cpu_cyc = (i < 8); cpu_stb = (i < 8);
            cpu_adr = $urandom; cpu_sel = 4'($urandom);
            dma_cyc = 1; dma_stb = 1; dma_we = 1; dma_adr = $urandom; dma_wdat = $urandom;
            mem_ack = 1; mem_rdat = $urandom;
            #2;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (dut_out(k) !== model_out(k)) begin
                    n_fail++;
                    $display("FAIL rr_model[%0d] cyc %0d: got %h want %h", k, i, dut_out(k), model_out(k));
                end
            end
            if (i < 9) begin
                n_checks++;
                if (a_grant !== exp_a[i] || b_grant !== exp_b[i]) begin
                    n_fail++;
                    $display("FAIL rr_order cyc %0d: got rr=%b fixed=%b want %b/%b", i, a_grant, b_grant, exp_a[i], exp_b[i]);
                end
            end
            if (i == 9) begin
                n_checks++;
                if (b_grant !== 2'b10) begin
                    n_fail++;
                    $display("FAIL fixed_dma_after_cpu_drop: got %b want 10", b_grant);
                end
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int          seen = -1;
        logic        s_ack = 0, s_cack = 0;
        logic [31:0] s_dat = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            dma_cyc = (seen < 0); dma_stb = (seen < 0); dma_we = 1;
            dma_sel = 4'hF; dma_adr = 32'h100 + i; dma_wdat = $urandom;
            mem_ack = 0; mem_rdat = $urandom;
            #2;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (dut_out(k) !== model_out(k)) begin
                    n_fail++;
                    $display("FAIL timeout_model[%0d] cyc %0d: got %h want %h", k, i, dut_out(k), model_out(k));
                end
            end
            if (seen >= 0 && i == seen + 1) begin
                n_checks++;
                if (a_tmo !== 1'b0 || a_grant !== 2'b00) begin
                    n_fail++;
                    $display("FAIL timeout_after: got tmo=%b grant=%b want 0/00", a_tmo, a_grant);
                end
            end
            if (seen < 0 && a_tmo === 1'b1) begin
                seen = i; s_ack = a_dma_ack; s_cack = a_cpu_ack; s_dat = a_dma_dat;
            end
            tick();
        end
        n_checks++;
        if (seen != 1 + TO || s_ack !== 1'b1 || s_cack !== 1'b0 || s_dat !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL timeout_pulse: got cycle=%0d ack=%b cpu_ack=%b dat=%h want %0d/1/0/deadbeef",
                     seen, s_ack, s_cack, s_dat, 1 + TO);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            rst = (i == 4);
            if (i <= 1) begin cpu_cyc = 1; cpu_stb = 1; mem_ack = 1; mem_rdat = $urandom; end
            if (i >= 2) begin dma_cyc = 1; dma_stb = 1; dma_we = 1; dma_adr = $urandom; end
            if (i >= 5) begin cpu_cyc = 1; cpu_stb = 1; end
            #2;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (dut_out(k) !== model_out(k)) begin
                    n_fail++;
                    $display("FAIL reset_mid_model[%0d] cyc %0d: got %h want %h", k, i, dut_out(k), model_out(k));
                end
            end
            if (i == 3) begin
                n_checks++;
                if (a_grant !== 2'b10) begin
                    n_fail++;
                    $display("FAIL reset_mid_dma_grant: got %b want 10", a_grant);
                end
            end
            if (i == 5) begin
                n_checks++;
                if (a_mem_cyc !== 1'b0 || a_grant !== 2'b00 || a_cpu_ack !== 1'b0 || a_dma_ack !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_drop: got cyc=%b grant=%b acks=%b%b want 0/00/00",
                             a_mem_cyc, a_grant, a_cpu_ack, a_dma_ack);
                end
            end
            if (i == 6) begin
                n_checks++;
                if (a_grant !== 2'b01) begin
                    n_fail++;
                    $display("FAIL reset_mid_cpu_first: got %b want 01", a_grant);
                end
            end
            tick();
        end
        rst = 0;
    endtask

    task automatic test_idle_ack();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            mem_ack = 1; mem_rdat = $urandom;
            #2;
            n_checks++;
            if (a_cpu_ack !== 1'b0 || a_dma_ack !== 1'b0 || b_cpu_ack !== 1'b0 || b_dma_ack !== 1'b0 ||
                a_grant !== 2'b00 || b_grant !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_ack cyc %0d: got acks=%b%b%b%b grants=%b/%b want 0000/00/00",
                         i, a_cpu_ack, a_dma_ack, b_cpu_ack, b_dma_ack, a_grant, b_grant);
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit slow;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            slow     = ((i / 50) % 2) == 1;
            rst      = ($urandom_range(0, 60) == 0);
            cpu_cyc  = slow ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0);
            cpu_stb  = ($urandom_range(0, 3) != 0);
            cpu_we   = 1'($urandom); cpu_sel = 4'($urandom);
            cpu_adr  = $urandom; cpu_wdat = $urandom;
            dma_cyc  = slow ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0);
            dma_stb  = ($urandom_range(0, 3) != 0);
            dma_we   = 1'($urandom); dma_sel = 4'($urandom);
            dma_adr  = $urandom; dma_wdat = $urandom;
            mem_ack  = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
            mem_rdat = $urandom;
            #2;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (dut_out(k) !== model_out(k)) begin
                    n_fail++;
                    $display("FAIL random_model[%0d] cyc %0d: got %h want %h", k, i, dut_out(k), model_out(k));
                end
            end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_idle_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
